// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: access-width codes, default widths and
// the byte-lane helpers used by the memory stage.
package mips_pkg;

   localparam int NB_DATA_DEF = 32;
   localparam int NB_ADDR_DEF = 10;
   localparam int NB_REG_DEF  = 5;

   localparam logic [1:0] WIDTH_BYTE = 2'b00;
   localparam logic [1:0] WIDTH_HALF = 2'b01;
   localparam logic [1:0] WIDTH_WORD = 2'b10;

   // Width code 2'b11 falls into the default branch and behaves as a word.
   function automatic logic [3:0] lane_enable(input logic [1:0] width,
                                              input logic [1:0] lane);
      logic [3:0] en;
      en = 4'b1111;
      case (width)
         WIDTH_BYTE: en = 4'b0001 << lane;
         WIDTH_HALF: en = lane[1] ? 4'b1100 : 4'b0011;
         default:    en = 4'b1111;
      endcase
      return en;
   endfunction

   function automatic logic is_misaligned(input logic [1:0] width,
                                          input logic [1:0] lane);
      return ((width == WIDTH_HALF) && lane[0]) ||
             (width[1] && (lane != 2'b00));
   endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-lane-enabled word RAM: one write port, one combinational read port
// and one combinational debug read port. Contents are not reset.
module data_memory
   import mips_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_ADDR = NB_ADDR_DEF
) (
   input  logic               clk,
   input  logic [3:0]         wr_en,
   input  logic [NB_ADDR-3:0] wr_idx,
   input  logic [NB_DATA-1:0] wr_data,
   input  logic [NB_ADDR-3:0] rd_idx,
   output logic [NB_DATA-1:0] rd_data,
   input  logic [NB_ADDR-3:0] dbg_idx,
   output logic [NB_DATA-1:0] dbg_data
);

   localparam int DEPTH = 1 << (NB_ADDR - 2);

   logic [NB_DATA-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (wr_en[b]) begin
            mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   // Reads see the pre-write word during a write cycle.
   assign rd_data  = mem[rd_idx];
   assign dbg_data = mem[dbg_idx];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: aligned byte/half/word loads and stores on the
// data memory, followed by the MEM/WB pipeline register.
module mem_stage
   import mips_pkg::*;
#(
   parameter int NB_DATA = NB_DATA_DEF,
   parameter int NB_ADDR = NB_ADDR_DEF,
   parameter int NB_REG  = NB_REG_DEF
) (
   input  logic               clk,
   input  logic               i_reset,
   input  logic               i_step,
   input  logic               i_mem2reg,
   input  logic               i_memWrite,
   input  logic               i_regWrite,
   input  logic [1:0]         i_width,
   input  logic               i_sign_flag,
   input  logic [NB_REG-1:0]  i_write_reg,
   input  logic [NB_DATA-1:0] i_result,
   input  logic [NB_DATA-1:0] i_data4Mem,
   input  logic [NB_ADDR-3:0] i_dbg_addr,
   output logic               o_mem2reg,
   output logic               o_regWrite,
   output logic [NB_REG-1:0]  o_write_reg,
   output logic [NB_DATA-1:0] o_result,
   output logic [NB_DATA-1:0] o_read_data,
   output logic [NB_DATA-1:0] o_wb_data,
   output logic               o_misaligned,
   output logic [NB_DATA-1:0] o_dbg_data
);

   logic [NB_ADDR-1:0] addr;
   logic [1:0]         lane;
   logic               mem_op;
   logic               misaligned;
   logic               mem_we;
   logic [3:0]         wr_en;
   logic [NB_DATA-1:0] wr_data;
   logic [NB_DATA-1:0] rd_word;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic [NB_DATA-1:0] load_ext;
   logic               unused_upper_addr;

   assign addr = i_result[NB_ADDR-1:0];
   assign lane = addr[1:0];
   // Address bits above NB_ADDR are dropped, so accesses wrap.
   assign unused_upper_addr = ^i_result[NB_DATA-1:NB_ADDR];

   assign mem_op     = i_mem2reg | i_memWrite;
   assign misaligned = mem_op & is_misaligned(i_width, lane);

   // i_step is the single advance strobe: when it is low nothing downstream
   // of EX/MEM moves -- the MEM/WB register holds and the memory is not written.
   // A write is also suppressed while reset is held low at the edge.
   assign mem_we = i_step & i_memWrite & ~misaligned & i_reset;
   assign wr_en  = {4{mem_we}} & lane_enable(i_width, lane);

   always_comb begin
      wr_data = i_data4Mem;
      case (i_width)
         WIDTH_BYTE: wr_data = {4{i_data4Mem[7:0]}};
         WIDTH_HALF: wr_data = {2{i_data4Mem[15:0]}};
         default:    wr_data = i_data4Mem;
      endcase
   end

   data_memory #(
      .NB_DATA (NB_DATA),
      .NB_ADDR (NB_ADDR)
   ) u_data_memory (
      .clk      (clk),
      .wr_en    (wr_en),
      .wr_idx   (addr[NB_ADDR-1:2]),
      .wr_data  (wr_data),
      .rd_idx   (addr[NB_ADDR-1:2]),
      .rd_data  (rd_word),
      .dbg_idx  (i_dbg_addr),
      .dbg_data (o_dbg_data)
   );

   always_comb begin
      byte_sel = rd_word[8*lane +: 8];
      half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];
      load_ext = rd_word;
      case (i_width)
         WIDTH_BYTE: load_ext = {{(NB_DATA-8){i_sign_flag & byte_sel[7]}}, byte_sel};
         WIDTH_HALF: load_ext = {{(NB_DATA-16){i_sign_flag & half_sel[15]}}, half_sel};
         default:    load_ext = rd_word;
      endcase
      if (misaligned) begin
         load_ext = '0;
      end
   end

   always_ff @(posedge clk or negedge i_reset) begin
      if (!i_reset) begin
         o_mem2reg    <= 1'b0;
         o_regWrite   <= 1'b0;
         o_write_reg  <= '0;
         o_result     <= '0;
         o_read_data  <= '0;
         o_misaligned <= 1'b0;
      end else if (i_step) begin
         o_mem2reg    <= i_mem2reg;
         o_regWrite   <= i_regWrite & ~(i_mem2reg & misaligned);
         o_write_reg  <= i_write_reg;
         o_result     <= i_result;
         o_read_data  <= load_ext;
         o_misaligned <= misaligned;
      end
   end

   assign o_wb_data = o_mem2reg ? o_read_data : o_result;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: byte-addressed reference model, a
// per-cycle compare process and directed literal checks.
module tb_mem_stage;
   import mips_pkg::*;

   localparam int NB_DATA = 32;
   localparam int NB_ADDR = 10;
   localparam int NB_REG  = 5;
   localparam int NBYTES  = 1 << NB_ADDR;

   logic               clk;
   logic               i_reset;
   logic               i_step;
   logic               i_mem2reg;
   logic               i_memWrite;
   logic               i_regWrite;
   logic [1:0]         i_width;
   logic               i_sign_flag;
   logic [NB_REG-1:0]  i_write_reg;
   logic [NB_DATA-1:0] i_result;
   logic [NB_DATA-1:0] i_data4Mem;
   logic [NB_ADDR-3:0] i_dbg_addr;
   logic               o_mem2reg;
   logic               o_regWrite;
   logic [NB_REG-1:0]  o_write_reg;
   logic [NB_DATA-1:0] o_result;
   logic [NB_DATA-1:0] o_read_data;
   logic [NB_DATA-1:0] o_wb_data;
   logic               o_misaligned;
   logic [NB_DATA-1:0] o_dbg_data;

   mem_stage #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR), .NB_REG(NB_REG)) dut (
      .clk          (clk),
      .i_reset      (i_reset),
      .i_step       (i_step),
      .i_mem2reg    (i_mem2reg),
      .i_memWrite   (i_memWrite),
      .i_regWrite   (i_regWrite),
      .i_width      (i_width),
      .i_sign_flag  (i_sign_flag),
      .i_write_reg  (i_write_reg),
      .i_result     (i_result),
      .i_data4Mem   (i_data4Mem),
      .i_dbg_addr   (i_dbg_addr),
      .o_mem2reg    (o_mem2reg),
      .o_regWrite   (o_regWrite),
      .o_write_reg  (o_write_reg),
      .o_result     (o_result),
      .o_read_data  (o_read_data),
      .o_wb_data    (o_wb_data),
      .o_misaligned (o_misaligned),
      .o_dbg_data   (o_dbg_data)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [7:0]         mem_b [NBYTES];
   logic               exp_m2r, exp_rw, exp_mis;
   logic [NB_REG-1:0]  exp_wreg;
   logic [NB_DATA-1:0] exp_res, exp_rd;
   logic [NB_DATA-1:0] exp_q [$];
   int                 vec_cnt  = 0;
   int                 miss_cnt = 0;
   bit                 chk_en   = 0;
   bit                 dbg_en   = 0;

   function automatic logic [31:0] model_word(input int idx);
      return {mem_b[4*idx+3], mem_b[4*idx+2], mem_b[4*idx+1], mem_b[4*idx]};
   endfunction

   task automatic model_clear();
      exp_m2r = 0; exp_rw = 0; exp_mis = 0; exp_wreg = '0; exp_res = '0; exp_rd = '0;
   endtask

   // Applies one rising edge of the architectural rules to the model.
   task automatic model_edge();
      int a, sz;
      logic [31:0] v;
      bit mis;
      if (i_reset && i_step) begin
         a  = int'(i_result[NB_ADDR-1:0]);
         sz = (i_width == WIDTH_BYTE) ? 1 : (i_width == WIDTH_HALF) ? 2 : 4;
         mis = (i_mem2reg || i_memWrite) && (a % sz != 0);
         v = '0;
         if (!mis) begin
            for (int k = 0; k < sz; k++) v |= 32'(mem_b[a+k]) << (8*k);
            if (sz < 4 && i_sign_flag && v[8*sz-1]) v |= ~((32'h1 << (8*sz)) - 1);
         end
         if (i_memWrite && !mis)
            for (int k = 0; k < sz; k++) mem_b[a+k] = 8'(i_data4Mem >> (8*k));
         exp_m2r  = i_mem2reg;
         exp_rw   = i_regWrite && !(i_mem2reg && mis);
         exp_wreg = i_write_reg;
         exp_res  = i_result;
         exp_rd   = v;
         exp_mis  = mis;
      end
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      vec_cnt++;
      if (act !== want) begin
         miss_cnt++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         exp_q.push_back(exp_m2r ? exp_rd : exp_res);
         check("mem2reg",   32'(o_mem2reg),    32'(exp_m2r));
         check("regWrite",  32'(o_regWrite),   32'(exp_rw));
         check("write_reg", 32'(o_write_reg),  32'(exp_wreg));
         check("result",    o_result,          exp_res);
         check("misaligned",32'(o_misaligned), 32'(exp_mis));
         check("wb_data",   o_wb_data,         exp_q.pop_front());
         if (exp_m2r) check("read_data", o_read_data, exp_rd);
         if (dbg_en)  check("dbg_data",  o_dbg_data,  model_word(int'(i_dbg_addr)));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic rand_inputs();
      int kind;
      kind        = $urandom_range(0, 9);
      i_mem2reg   = (kind <= 3) || (kind == 9);
      i_memWrite  = (kind >= 4 && kind <= 6) || (kind == 9);
      i_regWrite  = $urandom_range(0, 1);
      i_width     = 2'($urandom_range(0, 3));
      i_sign_flag = $urandom_range(0, 1);
      i_write_reg = NB_REG'($urandom);
      i_result    = $urandom;
      if ($urandom_range(0, 3) != 0) i_result[NB_ADDR-1:0] = NB_ADDR'($urandom_range(0, 63));
      i_data4Mem  = $urandom;
      i_dbg_addr  = (NB_ADDR-2)'($urandom_range(0, 15));
   endtask

   task automatic op(input bit m2r, input bit mw, input bit rw, input logic [1:0] w,
                     input bit s, input logic [31:0] r, input logic [31:0] d);
      i_step = 1; i_mem2reg = m2r; i_memWrite = mw; i_regWrite = rw;
      i_width = w; i_sign_flag = s; i_result = r; i_data4Mem = d;
      i_write_reg = NB_REG'($urandom);
      cycle();
      #2;
   endtask

   task automatic do_reset(input int n);
      i_reset = 0;
      model_clear();
      #1;
      check("rst_async_wb", o_wb_data, 32'h0);
      check("rst_async_mis", 32'(o_misaligned), 32'h0);
      repeat (n) begin
         rand_inputs();
         i_step = 1;
         cycle();
      end
      i_reset = 1;
      i_step  = 0;
      repeat (2) begin
         rand_inputs();
         cycle();
      end
      check("rst_hold_wb", o_wb_data, 32'h0);
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] pre;

   initial begin
      i_reset = 0; i_step = 0;
      rand_inputs();
      chk_en = 1;
      do_reset(3);

      // Define every memory word before loads and debug reads are checked.
      for (int i = 0; i < (NBYTES/4); i++) op(0, 1, 0, WIDTH_WORD, 0, 32'(4*i), $urandom);
      dbg_en = 1;

      // Word store / load and debug read.
      op(0, 1, 0, WIDTH_WORD, 0, 32'h010, 32'hDEADBEEF);
      i_dbg_addr = 4;
      op(1, 0, 1, WIDTH_WORD, 1, 32'h010, 32'h0);
      check("lw_dut",   o_wb_data,  32'hDEADBEEF);
      check("lw_model", exp_rd,     32'hDEADBEEF);
      check("dbg_w4",   o_dbg_data, 32'hDEADBEEF);

      // Byte/half store and extension.
      i_dbg_addr = 8;
      op(0, 1, 0, WIDTH_WORD, 0, 32'h020, 32'h11223344);
      op(0, 1, 0, WIDTH_BYTE, 0, 32'h021, 32'hAAAAAA80);
      check("sb_dut",   o_dbg_data,   32'h11228044);
      check("sb_model", model_word(8), 32'h11228044);
      op(1, 0, 1, WIDTH_BYTE, 1, 32'h021, 32'h0);
      check("lb_dut",   o_wb_data, 32'hFFFFFF80);
      check("lb_model", exp_rd,    32'hFFFFFF80);
      op(1, 0, 1, WIDTH_BYTE, 0, 32'h021, 32'h0);
      check("lbu_dut",  o_wb_data, 32'h00000080);
      op(1, 0, 1, WIDTH_HALF, 0, 32'h022, 32'h0);
      check("lhu_dut",  o_wb_data, 32'h00001122);
      check("lhu_model", exp_rd,   32'h00001122);

      // Misaligned store and load.
      i_dbg_addr = 4;
      op(0, 1, 0, WIDTH_WORD, 0, 32'h013, 32'h55555555);
      check("sw_mis_flag", 32'(o_misaligned), 32'h1);
      check("sw_mis_mem",  o_dbg_data, 32'hDEADBEEF);
      op(1, 0, 1, WIDTH_HALF, 1, 32'h011, 32'h0);
      check("lh_mis_rd",   o_read_data, 32'h0);
      check("lh_mis_rw",   32'(o_regWrite), 32'h0);
      check("lh_mis_flag", 32'(o_misaligned), 32'h1);

      // Step gating.
      i_dbg_addr = 12;
      pre = model_word(12);
      i_step = 0; i_mem2reg = 0; i_memWrite = 1; i_regWrite = 0;
      i_width = WIDTH_WORD; i_result = 32'h030; i_data4Mem = 32'hCAFEF00D;
      repeat (3) cycle();
      #2;
      check("gate_mem",    o_dbg_data, pre);
      check("gate_result", o_result,   32'h011);
      i_step = 1;
      cycle();
      #2;
      check("step_mem",    o_dbg_data, 32'hCAFEF00D);
      check("step_result", o_result,   32'h030);

      // Address wrap and ALU pass-through.
      i_dbg_addr = 1;
      op(0, 1, 0, WIDTH_WORD, 0, 32'h00000404, 32'h12345678);
      check("wrap_mem", o_dbg_data, 32'h12345678);
      op(0, 0, 1, WIDTH_WORD, 0, 32'h7, 32'h0);
      check("alu_wb",  o_wb_data, 32'h7);
      check("alu_m2r", 32'(o_mem2reg), 32'h0);
      check("alu_rw",  32'(o_regWrite), 32'h1);

      // Randomized traffic with occasional mid-run resets.
      for (int n = 0; n < 3000; n++) begin
         rand_inputs();
         i_step = ($urandom_range(0, 9) != 0);
         cycle();
         if (n % 700 == 699) do_reset(2);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
